// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller and its RAM.
package dmem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int DEF_DATA_W = 16;
  localparam int BE_W       = DEF_DATA_W / 8;

  // be_mask works on the widest supported word; callers size-cast in and out.
  localparam int MAX_BE_W = 16;

  function automatic logic [MAX_BE_W*8-1:0] be_mask(input logic [MAX_BE_W-1:0] be);
    logic [MAX_BE_W*8-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with per-byte write enable and a registered read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 1024,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mask;

  assign mask = DATA_W'(be_mask(MAX_BE_W'(be)));

  // NOTE: the array and read register carry no reset; a reset term would stop
  // the tools mapping this onto block RAM, and the controller masks stale data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, range check, response
// pipeline with optional output register, and post-reset zero-fill.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                init_busy
);

  localparam int NBE = DATA_W / 8;
  localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam longint unsigned SPAN = 64'd1 << ADDR_W;
  localparam bit FULL_MAP = (64'(DEPTH) >= SPAN);

  state_t          state, state_nxt;
  logic [CW-1:0]   clr_cnt, clr_nxt;
  logic            accept, in_range;
  logic            ram_en, ram_we;
  logic [CW-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [NBE-1:0]  ram_be;

  generate
    if (FULL_MAP) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_chk
      assign in_range = req_addr < ADDR_W'(DEPTH);
    end
  endgenerate

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= (INIT_ZERO != 0) ? INIT : RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    req_ready = 1'b0;
    init_busy = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr[CW-1:0];
    ram_wdata = req_wdata;
    ram_be    = req_be;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        ram_be    = '1;
        if (clr_cnt == LAST) begin
          state_nxt = RUN;
          clr_nxt   = '0;
        end else begin
          clr_nxt = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        req_ready = 1'b1;
        ram_en    = req_valid && in_range;
        ram_we    = req_we;
      end
      default: state_nxt = RUN;
    endcase
    // While reset is held nothing is accepted and the RAM is left alone.
    if (!rst) begin
      req_ready = 1'b0;
      ram_en    = 1'b0;
    end
  end

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  logic p1_valid, p1_err, p1_load;
  logic [DATA_W-1:0] p1_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_valid <= 1'b0;
      p1_err   <= 1'b0;
      p1_load  <= 1'b0;
    end else begin
      p1_valid <= accept;
      p1_err   <= accept && !in_range;
      p1_load  <= accept && in_range && !req_we;
    end
  end

  assign p1_rdata = p1_load ? ram_rdata : '0;

  // Outputs are gated by rst so a response due in a cycle where reset is
  // already asserted is discarded, matching the synchronous flush.
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              p2_valid, p2_err;
      logic [DATA_W-1:0] p2_rdata;

      always_ff @(posedge clk) begin
        if (!rst) begin
          p2_valid <= 1'b0;
          p2_err   <= 1'b0;
          p2_rdata <= '0;
        end else begin
          p2_valid <= p1_valid;
          p2_err   <= p1_err;
          p2_rdata <= p1_rdata;
        end
      end

      assign resp_valid = rst && p2_valid;
      assign resp_err   = rst && p2_err;
      assign resp_rdata = rst ? p2_rdata : '0;
    end else begin : g_direct
      assign resp_valid = rst && p1_valid;
      assign resp_err   = rst && p1_err;
      assign resp_rdata = rst ? p1_rdata : '0;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two DEPTH=16 instances (OUT_REG=0 and 1) share
// one request stream and are checked at latency 1 and 2 respectively.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [dmem_pkg::BE_W-1:0] req_be = '0;

  logic        r0_ready, r0_valid, r0_err, r0_busy;
  logic [15:0] r0_rdata;
  logic        r1_ready, r1_valid, r1_err, r1_busy;
  logic [15:0] r1_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .OUT_REG(0), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r0_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r0_valid), .resp_rdata(r0_rdata), .resp_err(r0_err), .init_busy(r0_busy)
  );

  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .OUT_REG(1), .INIT_ZERO(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r1_valid), .resp_rdata(r1_rdata), .resp_err(r1_err), .init_busy(r1_busy)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [1:0] be, input logic [15:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic valid, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
    req_valid = valid; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
  endtask

  task automatic check_resp(input string tag, input logic valid, input logic [15:0] rdata,
                            input logic err, input logic [15:0] exp_rdata, input logic exp_err);
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, " err"},   32'(err),   32'(exp_err));
  endtask

  task automatic check_idle(input string tag, input logic valid, input logic [15:0] rdata,
                            input logic err);
    check({tag, " idle"}, {15'd0, valid, rdata}, 32'd0);
    check({tag, " idle err"}, 32'(err), 32'd0);
  endtask

  // Hold reset, check reset values, release, and time the zero-fill.
  task automatic do_init();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    repeat (2) @(negedge clk);
    check("rst u0 flags", {r0_busy, r0_ready, r0_valid, r0_err}, 32'b1000);
    check("rst u1 flags", {r1_busy, r1_ready, r1_valid, r1_err}, 32'b1000);
    check("rst rdata", {r0_rdata, r1_rdata}, 32'd0);
    rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("init c%0d u0", i), {r0_busy, r0_ready, r0_valid}, 32'b100);
      check($sformatf("init c%0d u1", i), {r1_busy, r1_ready, r1_valid}, 32'b100);
    end
    @(negedge clk);
    check("init done u0", {r0_busy, r0_ready}, 32'b01);
    check("init done u1", {r1_busy, r1_ready}, 32'b01);
  endtask

  initial begin
    // we, addr, wdata, be, exp_rdata, exp_err
    for (int a = 0; a < 16; a++) add(1'b0, 16'(a), 16'h0, 2'b00, 16'h0000, 1'b0);
    add(1'b1, 16'd5,    16'hBEEF, 2'b11, 16'h0000, 1'b0);
    add(1'b0, 16'd5,    16'h0000, 2'b00, 16'hBEEF, 1'b0);
    add(1'b1, 16'd3,    16'h1234, 2'b11, 16'h0000, 1'b0);
    add(1'b1, 16'd3,    16'hAB00, 2'b10, 16'h0000, 1'b0);
    add(1'b0, 16'd3,    16'h0000, 2'b00, 16'hAB34, 1'b0);
    add(1'b1, 16'd7,    16'h5555, 2'b00, 16'h0000, 1'b0);
    add(1'b0, 16'd7,    16'h0000, 2'b00, 16'h0000, 1'b0);
    add(1'b1, 16'd16,   16'hFFFF, 2'b11, 16'h0000, 1'b1);
    add(1'b0, 16'd16,   16'h0000, 2'b00, 16'h0000, 1'b1);
    add(1'b0, 16'd0,    16'h0000, 2'b00, 16'h0000, 1'b0);
    add(1'b1, 16'd15,   16'hC3C3, 2'b01, 16'h0000, 1'b0);
    add(1'b0, 16'd15,   16'h0000, 2'b00, 16'h00C3, 1'b0);
    add(1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1);
    add(1'b1, 16'd2,    16'h1111, 2'b11, 16'h0000, 1'b0);
    add(1'b0, 16'd0,    16'h0000, 2'b00, 16'h0000, 1'b0);
    add(1'b0, 16'd1,    16'h0000, 2'b00, 16'h0000, 1'b0);
    add(1'b0, 16'd2,    16'h0000, 2'b00, 16'h1111, 1'b0);

    do_init();

    for (int k = 0; k <= vecs.size() + 1; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= vecs.size())
        check_resp($sformatf("u0 v%0d", k-1), r0_valid, r0_rdata, r0_err,
                   vecs[k-1].exp_rdata, vecs[k-1].exp_err);
      else
        check_idle($sformatf("u0 k%0d", k), r0_valid, r0_rdata, r0_err);
      if (k >= 2)
        check_resp($sformatf("u1 v%0d", k-2), r1_valid, r1_rdata, r1_err,
                   vecs[k-2].exp_rdata, vecs[k-2].exp_err);
      else
        check_idle($sformatf("u1 k%0d", k), r1_valid, r1_rdata, r1_err);
      if (k < vecs.size())
        drive(1'b1, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be);
      else
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    end
    @(negedge clk);
    check_idle("tail u0", r0_valid, r0_rdata, r0_err);
    check_idle("tail u1", r1_valid, r1_rdata, r1_err);

    // Load accepted, then reset in the following cycle: its response is dropped.
    drive(1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    rst = 1'b0;
    #1;
    check("midrst u0 valid", 32'(r0_valid), 32'd0);
    check("midrst u1 valid", 32'(r1_valid), 32'd0);
    @(negedge clk);
    check("midrst later", {r0_valid, r1_valid}, 32'd0);
    do_init();

    // Address 5 held 0xBEEF before the reset; zero-fill must have cleared it.
    drive(1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    check_resp("post u0", r0_valid, r0_rdata, r0_err, 16'h0000, 1'b0);
    check("post u1 early", 32'(r1_valid), 32'd0);
    @(negedge clk);
    check_resp("post u1", r1_valid, r1_rdata, r1_err, 16'h0000, 1'b0);
    check_idle("post u0 end", r0_valid, r0_rdata, r0_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the single-cycle CPU datapath. It replaces the fixed 16-bit BRAM wrapper with an inferred synchronous RAM and a valid/ready request port. Beyond the old wrapper it adds byte-enable writes, an optional output pipeline register, address range checking with an error flag, and a post-reset zero-fill sequence. It sits between the ALU result/store-data path and the writeback mux.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8.
ADDR_W, 16, request address width; addresses are word indices.
DEPTH, 1024, number of words implemented; must be ≤ 2^ADDR_W.
OUT_REG, 0, 1 adds a registered output stage, so read latency becomes 2.
INIT_ZERO, 1, 1 zero-fills all of RAM after every reset before accepting requests.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
req_be  in  DATA_W/8  byte enables for stores; bit i covers byte i
resp_valid  out  1  one-cycle pulse per accepted request
resp_rdata  out  DATA_W  load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid; address ≥ DEPTH
init_busy  out  1  zero-fill in progress

Behaviour:
- Clock and reset: clk is the clock. rst is synchronous and active-low. Every state element resets on a rising clk edge with rst=0.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. init_busy=1 if INIT_ZERO=1, otherwise 0. The pipeline is flushed.
- FSM states: INIT and RUN.
  - Reset enters INIT if INIT_ZERO=1, otherwise RUN.
  - INIT: clr_cnt runs 0..DEPTH-1, writing 0 with all byte enables set, one word per cycle. At clr_cnt=DEPTH-1 the FSM moves to RUN. INIT lasts exactly DEPTH cycles.
  - RUN: req_ready=1 continuously; there is no backpressure.
- Acceptance: a request is accepted on an edge where req_valid && req_ready.
- Store: RAM write occurs at the accept edge. Only bytes with req_be[i]=1 are updated.
  - req_be=0 is a legal no-op write; it still produces a response.
- Load: RAM is read synchronously at the accept edge.
  - OUT_REG=0: resp_valid and resp_rdata appear in the cycle after acceptance (latency 1).
  - OUT_REG=1: they appear 2 cycles after acceptance.
- Every accepted request yields exactly one resp_valid pulse, in order. Stores and loads have the same latency.
- Range check: if req_addr ≥ DEPTH, the RAM is not accessed and nothing is written. The response has resp_err=1 and resp_rdata=0. There is no address wrap-around or aliasing.
- Back-to-back requests: one request per cycle at full rate.
  - A load to address A accepted in the cycle after a store to A returns the new data.
  - A load and a store cannot coincide, because there is one request per cycle.
- Outside a response pulse, resp_rdata and resp_err hold 0.
- Reset mid-operation: in-flight responses are discarded (no resp_valid after reset). RAM contents are re-zeroed if INIT_ZERO=1, otherwise retained. INIT restarts at clr_cnt=0.
- Widths: clr_cnt is $clog2(DEPTH) bits. The range compare is done at ADDR_W bits.

Decomposition:
- Package dmem_pkg holds:
  - state enum {INIT, RUN}
  - function be_mask(be) that expands byte enables to a bit mask
  - localparam BE_W = DATA_W/8
- Sub-module dmem_ram: single-port synchronous RAM with per-byte write enable and a registered read, parametrised by DATA_W and DEPTH.
- The FSM, range check, response pipeline and OUT_REG stage stay in dmem_ctrl.

Test Plan:
- Init (DEPTH=16, INIT_ZERO=1): release rst → init_busy=1 and req_ready=0 for 16 cycles, then req_ready=1; a load of every address returns 0x0000.
- Store 0xBEEF to addr 5 with be=2'b11, then load 5 the next cycle → resp_valid 1 cycle after each accept; load returns 0xBEEF and resp_err=0.
- Byte enables: store 0x1234 to addr 3 with be=11, then 0xAB00 with be=10, then load 3 → 0xAB34.
- Out of range (DEPTH=16): store 0xFFFF to addr 16, then load addr 16 → resp_err=1 and rdata=0 on both responses; load addr 0 is still unchanged.
- OUT_REG=1: stream loads of addrs 0,1,2 in consecutive cycles → three resp_valid pulses in order, each 2 cycles after its accept, with correct data.
- Reset mid-operation: accept a load, assert rst in the next cycle → no resp_valid for that load; after re-init the previously stored value reads 0 (INIT_ZERO=1).
